usb_cmd_parser: RTL and testbench

Downstream consumer of the FX3 slave-FIFO read path. It takes the per-cycle command word stream (`cmd_valid`/`cmd_data`) produced when the host writes to the FPGA. It decodes one packet per contiguous `cmd_valid` run and issues register-write strobes to the design's control register bank. It reports each packet's outcome and keeps a saturating error count.

---
 rtl/usb_cmd_pkg.sv | 11 +
 rtl/usb_cmd_parser_if.sv | 23 ++
 rtl/usb_cmd_parser.sv | 123 ++++++++++++
 tb/tb_usb_cmd_parser.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/usb_cmd_pkg.sv
// usb_cmd_pkg: shared constants, header field positions and FSM state type for the command parser
package usb_cmd_pkg;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam int FIELD_W = 8;
  localparam int SYNC_LSB = 24;
  localparam int OP_LSB = 16;
  localparam int ADDR_LSB = 8;
  localparam int CNT_LSB = 0;
  typedef enum logic [1:0] {IDLE, PAYLOAD, TAIL, DRAIN} state_t;
endpackage

// File: rtl/usb_cmd_parser_if.sv
// usb_cmd_parser_if: command word stream in, register write strobes and packet outcome out
interface usb_cmd_parser_if #(
  parameter int ADDR_W = 8,
  parameter int ERR_W = 16
);
  import usb_cmd_pkg::*;
  logic cmd_valid;
  logic [31:0] cmd_data;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0] wr_data;
  logic pkt_done;
  logic pkt_err;
  logic [ERR_W-1:0] err_cnt;
  modport master (
    output cmd_valid, cmd_data,
    input wr_en, wr_addr, wr_data, pkt_done, pkt_err, err_cnt
  );
  modport slave (
    input cmd_valid, cmd_data,
    output wr_en, wr_addr, wr_data, pkt_done, pkt_err, err_cnt
  );
endinterface

// File: rtl/usb_cmd_parser.sv
// usb_cmd_parser: decodes one packet per cmd_valid run into register writes; optional trailing XOR checksum when USB_CMD_CHECKSUM_EN is defined
module usb_cmd_parser
  import usb_cmd_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int ERR_W = 16
) (
  input logic clk,
  input logic rst_n,
  usb_cmd_parser_if.slave bus
);
  state_t state_q, state_d;
  logic [FIELD_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic pkt_done_q, pkt_done_d;
  logic pkt_err_q, pkt_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic hdr_ok, tail_ok;
`ifdef USB_CMD_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
  logic pend_q, pend_d;
  assign tail_ok = !pend_q;
`else
  assign tail_ok = 1'b1;
`endif
  assign hdr_ok = bus.cmd_data[SYNC_LSB +: FIELD_W] == SYNC && bus.cmd_data[OP_LSB +: FIELD_W] == OP_WRITE;
  // next-state, write strobe and outcome decode; a packet is good only if it falls while in TAIL with nothing pending
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    addr_d = addr_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pkt_done_d = 1'b0;
    pkt_err_d = 1'b0;
`ifdef USB_CMD_CHECKSUM_EN
    csum_d = csum_q;
    pend_d = pend_q;
`endif
    if (!bus.cmd_valid) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        pkt_done_d = state_q == TAIL && tail_ok;
        pkt_err_d = !pkt_done_d;
      end
    end else begin
      case (state_q)
        IDLE: begin
          rem_d = bus.cmd_data[CNT_LSB +: FIELD_W];
          addr_d = ADDR_W'(bus.cmd_data[ADDR_LSB +: FIELD_W]);
          state_d = !hdr_ok ? DRAIN : (rem_d != '0 ? PAYLOAD : TAIL);
`ifdef USB_CMD_CHECKSUM_EN
          csum_d = bus.cmd_data;
          pend_d = 1'b1;
`endif
        end
        PAYLOAD: begin
          wr_en_d = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = bus.cmd_data;
          addr_d = addr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          state_d = rem_q == 8'd1 ? TAIL : PAYLOAD;
`ifdef USB_CMD_CHECKSUM_EN
          csum_d = csum_q ^ bus.cmd_data;
`endif
        end
        TAIL: begin
`ifdef USB_CMD_CHECKSUM_EN
          pend_d = 1'b0;
          state_d = pend_q && bus.cmd_data == csum_q ? TAIL : DRAIN;
`else
          state_d = DRAIN;
`endif
        end
        default: state_d = DRAIN;
      endcase
    end
    err_cnt_d = (pkt_err_d && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
  end
  // state and registered outputs; reset clears everything with no outcome pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q <= '0;
      addr_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pkt_done_q <= 1'b0;
      pkt_err_q <= 1'b0;
      err_cnt_q <= '0;
`ifdef USB_CMD_CHECKSUM_EN
      csum_q <= '0;
      pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      addr_q <= addr_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pkt_done_q <= pkt_done_d;
      pkt_err_q <= pkt_err_d;
      err_cnt_q <= err_cnt_d;
`ifdef USB_CMD_CHECKSUM_EN
      csum_q <= csum_d;
      pend_q <= pend_d;
`endif
    end
  end
  assign bus.wr_en = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.pkt_done = pkt_done_q;
  assign bus.pkt_err = pkt_err_q;
  assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_usb_cmd_parser.sv
// tb_usb_cmd_parser: directed packets with write/outcome scoreboards; follows USB_CMD_CHECKSUM_EN
module tb_usb_cmd_parser;
  localparam int ADDR_W = 8;
  localparam int ERR_W = 4;
`ifdef USB_CMD_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [39:0] exp_w[$];
  logic [1:0] exp_o[$];
  int wcyc[$];
  logic [31:0] pl[$];
  usb_cmd_parser_if #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) bus ();
  usb_cmd_parser #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [31:0] hdr, input bit with_csum);
    logic [31:0] c;
    c = hdr;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data = hdr;
    foreach (pl[i]) begin
      @(posedge clk); #1;
      bus.cmd_data = pl[i];
      c = c ^ pl[i];
    end
    if (with_csum && CSUM_EN) begin
      @(posedge clk); #1;
      bus.cmd_data = c;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data = '0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en) begin
        chk("wr_expected", 64'(exp_w.size() != 0), 64'd1);
        if (exp_w.size() != 0) chk("wr", 64'({bus.wr_addr, bus.wr_data}), 64'(exp_w.pop_front()));
        wcyc.push_back(cyc);
      end
      if (bus.pkt_done || bus.pkt_err) begin
        chk("outcome_expected", 64'(exp_o.size() != 0), 64'd1);
        if (exp_o.size() != 0) chk("outcome", 64'({bus.pkt_done, bus.pkt_err}), 64'(exp_o.pop_front()));
      end
    end
  end
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data = '0;
    #2;
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_done", 64'(bus.pkt_done), 64'd0);
    chk("rst_err", 64'(bus.pkt_err), 64'd0);
    chk("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    wcyc.delete();
    pl = '{32'h1111_1111, 32'h2222_2222};
    exp_w.push_back({8'h10, 32'h1111_1111});
    exp_w.push_back({8'h11, 32'h2222_2222});
    exp_o.push_back(2'b10);
    send(32'hA501_1002, 1'b1);
    idle(3);
    chk("b2b_count", 64'(wcyc.size()), 64'd2);
    chk("b2b_gap", 64'(wcyc[1] - wcyc[0]), 64'd1);
    chk("cnt_basic", 64'(bus.err_cnt), 64'd0);
    pl = '{32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};
    exp_w.push_back({8'hFE, 32'hDEAD_0001});
    exp_w.push_back({8'hFF, 32'hDEAD_0002});
    exp_w.push_back({8'h00, 32'hDEAD_0003});
    exp_o.push_back(2'b10);
    send(32'hA501_FE03, 1'b1);
    idle(3);
    pl = '{32'h1234_5678};
    exp_o.push_back(2'b01);
    send(32'h5A01_0001, 1'b1);
    idle(3);
    chk("cnt_badsync", 64'(bus.err_cnt), 64'd1);
    pl = '{32'hCAFE_0000, 32'hCAFE_0001};
    exp_w.push_back({8'h20, 32'hCAFE_0000});
    exp_w.push_back({8'h21, 32'hCAFE_0001});
    exp_o.push_back(2'b01);
    send(32'hA501_2004, 1'b0);
    idle(3);
    chk("cnt_trunc", 64'(bus.err_cnt), 64'd2);
    pl = '{32'hAAAA_AAAA, 32'hBBBB_BBBB};
    exp_w.push_back({8'h30, 32'hAAAA_AAAA});
    exp_o.push_back(2'b01);
    send(32'hA501_3001, 1'b0);
    idle(3);
    chk("cnt_extra", 64'(bus.err_cnt), 64'd3);
    pl = '{32'h0BAD_0BAD};
    exp_o.push_back(2'b01);
    send(32'hA502_4001, 1'b1);
    idle(3);
    chk("cnt_badop", 64'(bus.err_cnt), 64'd4);
    pl.delete();
    exp_o.push_back(2'b10);
    send(32'hA501_5000, 1'b1);
    idle(3);
    chk("cnt_n0", 64'(bus.err_cnt), 64'd4);
`ifdef USB_CMD_CHECKSUM_EN
    pl = '{32'h0000_00FF, 32'hA501_00FE};
    exp_w.push_back({8'h00, 32'h0000_00FF});
    exp_o.push_back(2'b10);
    send(32'hA501_0001, 1'b0);
    idle(3);
    chk("cnt_csum_ok", 64'(bus.err_cnt), 64'd4);
    pl = '{32'h0000_00FF, 32'hA501_00FF};
    exp_w.push_back({8'h00, 32'h0000_00FF});
    exp_o.push_back(2'b01);
    send(32'hA501_0001, 1'b0);
    idle(3);
    chk("cnt_csum_bad", 64'(bus.err_cnt), 64'd5);
    pl = '{32'h0000_00FF};
    exp_w.push_back({8'h00, 32'h0000_00FF});
    exp_o.push_back(2'b01);
    send(32'hA501_0001, 1'b0);
    idle(3);
    chk("cnt_csum_missing", 64'(bus.err_cnt), 64'd6);
`endif
    exp_w.push_back({8'h70, 32'h7777_0000});
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data = 32'hA501_7004;
    @(posedge clk); #1;
    bus.cmd_data = 32'h7777_0000;
    @(posedge clk); #1;
    bus.cmd_data = 32'h7777_0001;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("mid_rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("mid_rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("mid_rst_done", 64'(bus.pkt_done), 64'd0);
    chk("mid_rst_err", 64'(bus.pkt_err), 64'd0);
    chk("mid_rst_err_cnt", 64'(bus.err_cnt), 64'd0);
    bus.cmd_valid = 1'b0;
    bus.cmd_data = '0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    chk("post_rst_no_outcome", 64'(exp_o.size()), 64'd0);
    pl = '{32'h6666_6666};
    exp_w.push_back({8'h60, 32'h6666_6666});
    exp_o.push_back(2'b10);
    send(32'hA501_6001, 1'b1);
    idle(3);
    chk("cnt_after_rst", 64'(bus.err_cnt), 64'd0);
    pl.delete();
    for (int i = 0; i < (1 << ERR_W) + 1; i++) begin
      exp_o.push_back(2'b01);
      send(32'h5A00_0000, 1'b0);
      idle(2);
      if (i == (1 << ERR_W) - 2) chk("cnt_full", 64'(bus.err_cnt), 64'((1 << ERR_W) - 1));
    end
    chk("cnt_saturated", 64'(bus.err_cnt), 64'((1 << ERR_W) - 1));
    idle(2);
    chk("writes_drained", 64'(exp_w.size()), 64'd0);
    chk("outcomes_drained", 64'(exp_o.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
